// File: rtl/ifu_if.sv
// ifu_if: fetch-unit bundle -- imem request/response, decode handshake and execute redirect.
// When IFU_MISALIGN_CHK_EN is defined the bundle also carries fetch_fault and fault_pc.
interface ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFU_MISALIGN_CHK_EN
  logic        fetch_fault;
  logic [31:0] fault_pc;
`endif

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
`ifdef IFU_MISALIGN_CHK_EN
    , output fetch_fault, fault_pc
`endif
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
`ifdef IFU_MISALIGN_CHK_EN
    , input fetch_fault, fault_pc
`endif
  );
endinterface

// File: rtl/ifu.sv
// ifu: instruction fetch unit -- one outstanding imem request, one-entry instruction buffer, redirect flush.
// Optional IFU_MISALIGN_CHK_EN: misaligned redirect targets park the unit in a FAULT state.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic  clk,
  input  logic  rst_n,
  ifu_if.master bus
);

`ifdef IFU_MISALIGN_CHK_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;
`endif

  state_e      state_q, state_d, restart_s;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] redir_pc_s;
  logic        redir_take_s;
  logic        req_hs_s;

  assign redir_pc_s = {bus.redirect_pc[31:2], 2'b00};
  assign req_hs_s   = (state_q == REQ) && bus.imem_req_ready;

`ifdef IFU_MISALIGN_CHK_EN
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        redir_bad_s;

  assign redir_bad_s  = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign redir_take_s = bus.redirect_valid && !redir_bad_s;
`else
  logic unused_lsb_s;

  assign unused_lsb_s = ^bus.redirect_pc[1:0];
  assign redir_take_s = bus.redirect_valid;
`endif

  // Next-state, PC and buffer update; a usable redirect always retargets pc.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    if (redir_take_s) begin
      pc_d = redir_pc_s;
    end else begin
      pc_d = pc_q;
    end
`ifdef IFU_MISALIGN_CHK_EN
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (redir_bad_s) begin
      fault_d    = 1'b1;
      fault_pc_d = bus.redirect_pc;
    end else if (redir_take_s) begin
      fault_d    = 1'b0;
    end else begin
      fault_d    = fault_q;
    end
    restart_s = fault_d ? FAULT : REQ;
`else
    restart_s = REQ;
`endif
    case (state_q)
      IDLE: begin
        state_d = restart_s;
      end
      REQ: begin
        if (req_hs_s) begin
          // The old address is already issued; its response must be thrown away.
          state_d = WAIT;
          drop_d  = bus.redirect_valid;
        end else if (bus.redirect_valid) begin
          state_d = restart_s;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          if (drop_q || bus.redirect_valid) begin
            drop_d  = 1'b0;
            state_d = restart_s;
          end else begin
            inst_d    = bus.imem_resp_data;
            inst_pc_d = pc_q;
            pc_d      = pc_q + 32'd4;
            state_d   = HOLD;
          end
        end else if (bus.redirect_valid) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          state_d = restart_s;
        end else if (bus.inst_ready) begin
          state_d = REQ;
        end else begin
          state_d = HOLD;
        end
      end
`ifdef IFU_MISALIGN_CHK_EN
      FAULT: begin
        state_d = restart_s;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      inst_q     <= 32'h0000_0000;
      inst_pc_q  <= 32'h0000_0000;
`ifdef IFU_MISALIGN_CHK_EN
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0000_0000;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
`ifdef IFU_MISALIGN_CHK_EN
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
`endif
    end
  end

  // inst_valid is gated by the live redirect so a flushed word is never handed over.
  assign bus.imem_req_valid = (state_q == REQ);
  assign bus.imem_req_addr  = (state_q == REQ) ? pc_q : 32'h0000_0000;
  assign bus.inst_valid     = (state_q == HOLD) && !bus.redirect_valid;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
`ifdef IFU_MISALIGN_CHK_EN
  assign bus.fetch_fault    = fault_q;
  assign bus.fault_pc       = fault_pc_q;
`endif

endmodule
